// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART echo chain: ASCII control
//                and range constants, line_buf state encoding and a small
//                character-class helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DRAIN   = 2'd1,
        SEND_CR = 2'd2,
        SEND_LF = 2'd3
    } line_state_t;

    // True for characters that go into the line buffer (space through tilde).
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SP) && (c <= ASCII_TILDE);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/line_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : line_ram
//  Description : DEPTH x N simple dual-port memory, synchronous write and
//                synchronous (registered) read, shaped to map onto a BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int N     = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    // Write port and registered read port; no reset so the array stays a BRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule : line_ram
`default_nettype wire

// File: rtl/line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : line_buf
//  Description : Line assembly with backspace/delete editing. Printable
//                characters are buffered; CR releases the edited line to the
//                transmitter followed by CR LF. Overflowing characters are
//                dropped and flagged, never back-pressured.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buf
    import uart_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr,
    input  logic [N-1:0] i_data,
    output logic         o_bsy,
    input  logic         i_rd,
    output logic [N-1:0] o_data,
    output logic         o_rdy,
    output logic         o_ovf
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    line_state_t   state, state_nxt;
    logic [AW:0]   count, count_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic          ovf_nxt;
    logic          ram_we;
    logic [N-1:0]  ram_rdata;
    logic [N-1:0]  ctl_data, ctl_data_nxt;
    logic          wr, rd;
    logic [7:0]    ch;

    assign wr = i_wr && !o_bsy;
    assign rd = i_rd && o_rdy;
    assign ch = i_data[7:0];

    // Only the character code feeds the datapath; upper bus bits are ignored.
    generate
        if (N > 8) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^i_data[N-1:8];
        end
    endgenerate

    // Read address runs on next-rd_ptr so the registered RAM output lines up
    // with the cycle the drain state presents it.
    line_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (count[AW-1:0]),
        .wdata (N'(ch)),
        .raddr (rd_ptr_nxt),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, edit and drain decisions.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        ovf_nxt    = o_ovf;
        ram_we     = 1'b0;
        unique case (state)
            FILL: begin
                rd_ptr_nxt = '0;
                if (wr) begin
                    if (is_printable(ch)) begin
                        if (count < CNT_FULL) begin
                            ram_we    = 1'b1;
                            count_nxt = count + CNT_ONE;
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end else if (ch == ASCII_BS || ch == ASCII_DEL) begin
                        if (count != '0) begin
                            count_nxt = count - CNT_ONE;
                        end
                    end else if (ch == ASCII_CR) begin
                        state_nxt = (count != '0) ? DRAIN : SEND_CR;
                    end
                end
            end
            DRAIN: begin
                if (rd) begin
                    if ({1'b0, rd_ptr} == count - CNT_ONE) begin
                        state_nxt = SEND_CR;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_ONE;
                    end
                end
            end
            SEND_CR: begin
                if (rd) begin
                    state_nxt = SEND_LF;
                end
            end
            SEND_LF: begin
                if (rd) begin
                    state_nxt  = FILL;
                    count_nxt  = '0;
                    rd_ptr_nxt = '0;
                    ovf_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Control characters for the trailer; all ones outside the trailer.
    always_comb begin
        ctl_data_nxt = '1;
        if (state_nxt == SEND_CR) begin
            ctl_data_nxt = N'(ASCII_CR);
        end else if (state_nxt == SEND_LF) begin
            ctl_data_nxt = N'(ASCII_LF);
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            o_ovf    <= 1'b0;
            o_bsy    <= 1'b0;
            o_rdy    <= 1'b0;
            ctl_data <= '1;
        end else begin
            count    <= count_nxt;
            rd_ptr   <= rd_ptr_nxt;
            o_ovf    <= ovf_nxt;
            o_bsy    <= (state_nxt != FILL);
            o_rdy    <= (state_nxt != FILL);
            ctl_data <= ctl_data_nxt;
        end
    end

    // Output selects between two registers by the state register only, so
    // there is no path from any input to o_data within a cycle.
    assign o_data = (state == DRAIN) ? ram_rdata : ctl_data;

endmodule : line_buf
`default_nettype wire

// File: tb/tb_line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_line_buf
//  Description : Directed self-checking bench for line_buf (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buf;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] wdata;
    logic       bsy;
    logic       rd;
    logic [7:0] rdata;
    logic       rdy;
    logic       ovf;

    int tests;
    int fails;

    line_buf #(
        .N     (8),
        .DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wr    (wr),
        .i_data  (wdata),
        .o_bsy   (bsy),
        .i_rd    (rd),
        .o_data  (rdata),
        .o_rdy   (rdy),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] c);
        wr    = 1'b1;
        wdata = c;
        tick();
        wr    = 1'b0;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            put(s[i]);
        end
    endtask

    // Reads s then CR LF with i_rd held high, one character per cycle.
    task automatic drain(input string tag, input string s);
        logic [7:0] e;
        for (int i = 0; i < s.len() + 2; i++) begin
            e = (i < s.len()) ? s[i] : ((i == s.len()) ? 8'h0D : 8'h0A);
            chk({tag, "_rdy"}, 32'(rdy), 32'd1);
            chk({tag, "_data"}, 32'(rdata), 32'(e));
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        chk({tag, "_end_rdy"}, 32'(rdy), 32'd0);
        chk({tag, "_end_bsy"}, 32'(bsy), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        wdata = 8'h00;

        // Reset values
        tick();
        tick();
        chk("rst_bsy", 32'(bsy), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_data", 32'(rdata), 32'hFF);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic line
        put_str("abc");
        put(8'h0D);
        chk("t1_cr_bsy", 32'(bsy), 32'd1);
        chk("t1_cr_rdy", 32'(rdy), 32'd1);
        drain("t1", "abc");

        // Editing: LF and other control codes discarded, BS removes 'x'
        put_str("abx");
        put(8'h0A);
        put(8'h01);
        put(8'h08);
        put_str("c");
        put(8'h0D);
        drain("t2", "abc");

        // BS/DEL on empty line, then CR -> only CR LF
        put(8'h08);
        put(8'h7F);
        put(8'h08);
        put(8'h08);
        put(8'h0D);
        chk("t2e_data", 32'(rdata), 32'h0D);
        drain("t2e", "");

        // Overflow with DEPTH=4
        put_str("abcd");
        chk("t3_ovf_full", 32'(ovf), 32'd0);
        chk("t3_bsy_full", 32'(bsy), 32'd0);
        put_str("e");
        chk("t3_ovf_e", 32'(ovf), 32'd1);
        put_str("f");
        put(8'h0D);
        chk("t3_ovf_drain", 32'(ovf), 32'd1);
        drain("t3", "abcd");
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // Write during drain is ignored
        put_str("xy");
        put(8'h0D);
        put(8'h7A);
        chk("t4_bsy", 32'(bsy), 32'd1);
        chk("t4_hold", 32'(rdata), 32'h78);
        drain("t4", "xy");
        put_str("k");
        put(8'h0D);
        drain("t4n", "k");

        // Stall mid-drain
        put_str("wxyz");
        put(8'h0D);
        chk("t5_first", 32'(rdata), 32'h77);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_data", 32'(rdata), 32'h78);
            chk("t5_stall_rdy", 32'(rdy), 32'd1);
            tick();
        end
        drain("t5", "xyz");

        // Asynchronous reset mid-drain
        put_str("mn");
        put(8'h0D);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t6_pre", 32'(rdata), 32'h6E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bsy", 32'(bsy), 32'd0);
        chk("t6_rst_rdy", 32'(rdy), 32'd0);
        chk("t6_rst_data", 32'(rdata), 32'hFF);
        chk("t6_rst_ovf", 32'(ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        put_str("q");
        put(8'h0D);
        drain("t6", "q");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_line_buf
`default_nettype wire

// File: doc/line_buf.md
# line_buf

Line-assembly stage downstream of the case-swap transform in the UART echo path. Consumes characters one at a time and applies backspace/delete editing to a local line buffer. On carriage return it releases the edited line to the UART transmitter, followed by CR LF. Upstream and downstream sides use the same write/busy and read/ready handshake as the rest of the UART chain.

## Interface
- `N`, 8: data bus bit width; character codes are in the low 8 bits.
- `DEPTH`, 32: line buffer capacity in characters; power of two, 2..256.
- `AW`, `$clog2(DEPTH)`: derived; buffer address width.

- `i_clk` in 1: system clock, single clock domain.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_wr` in 1: write request from upstream.
- `i_data` in N: write data.
- `o_bsy` out 1: device busy; writes are ignored while high.
- `i_rd` in 1: read request from downstream.
- `o_data` out N: read data; registered.
- `o_rdy` out 1: result ready condition.
- `o_ovf` out 1: at least one printable character was dropped from the current line. Sticky until the line is released.

## Operation
- Accepted write: `wr = i_wr && !o_bsy`.
- Accepted read: `rd = i_rd && o_rdy`.
- States: `FILL`, `DRAIN`, `SEND_CR`, `SEND_LF`.
- Reset (any time, including mid-line or mid-drain):
  - state=`FILL`, count=0, rd_ptr=0.
  - `o_bsy`=0, `o_rdy`=0, `o_data`=all ones, `o_ovf`=0.
  - Buffer contents are don't-care.
- `FILL` (`o_bsy`=0, `o_rdy`=0). On `wr`, decode `i_data[7:0]`:
  - Printable 0x20..0x7E:
    - If count<DEPTH, store at mem[count] and increment count.
    - Otherwise drop the character and set `o_ovf`.
  - BS 0x08 or DEL 0x7F: if count>0, decrement count; else ignore.
  - CR 0x0D:
    - If count>0, go to `DRAIN` with rd_ptr=0.
    - Else go to `SEND_CR`.
  - All other codes (including LF) are accepted and discarded.
- `DRAIN` (`o_bsy`=1, `o_rdy`=1, `o_data`=mem[rd_ptr]):
  - On `rd`, increment rd_ptr.
  - When rd_ptr==count-1 is read, go to `SEND_CR`.
- `SEND_CR` (`o_bsy`=1, `o_rdy`=1, `o_data`=0x0D): on `rd`, go to `SEND_LF`.
- `SEND_LF` (`o_bsy`=1, `o_rdy`=1, `o_data`=0x0A):
  - On `rd`, go to `FILL`.
  - Clear count, rd_ptr and `o_ovf`.
- The upper bits of `o_data` are zero for buffered characters, CR and LF when N>8.
- count is AW+1 bits wide so DEPTH itself is representable; no wrap-around.
- A full buffer never asserts `o_bsy`: overflow drops characters and never stalls upstream.

## Timing
- All outputs are registered; no combinational input-to-output path.
- CR accepted at cycle t: `o_bsy`=1 and `o_rdy`=1 at t+1.
  - `o_data` at t+1 is the first buffered character, or 0x0D for an empty line.
- Read accepted at cycle t: the next character is on `o_data` at t+1 and `o_rdy` stays high.
  - Drain throughput is one character per cycle.
- Final LF read at cycle t: `o_rdy`=0 and `o_bsy`=0 at t+1; a write is accepted at t+1.
- Edit latency: write accepted at cycle t is reflected in count at t+1.
  - A BS at t+1 removes the character written at t.
- `i_rd` while `o_rdy`=0, or `i_wr` while `o_bsy`=1: no effect.
- Simultaneous `i_wr` and `i_rd` cannot both be accepted, because `o_bsy` and `o_rdy` are asserted together.
- `o_ovf` sets the cycle after the dropping write. It clears the cycle after the LF read.

## Structure
- Shared `uart_pkg` include holds:
  - character constants: `ASCII_BS` 0x08, `ASCII_LF` 0x0A, `ASCII_CR` 0x0D, `ASCII_DEL` 0x7F, `ASCII_SP` 0x20, `ASCII_TILDE` 0x7E;
  - the line_buf state encoding.
- Sub-module `line_ram`:
  - DEPTH x N memory, one synchronous write port and one synchronous read port;
  - infers BRAM on iCE40.
  - The read address is driven with next-rd_ptr so the read data is valid the cycle the state requires it.

## Test plan
- Write "abc", CR, then read continuously → reads "a","b","c",0x0D,0x0A on consecutive cycles; `o_bsy` falls the cycle after the LF read.
- Write "abx", BS, "c", CR → drains "abc",0x0D,0x0A; four BS on an empty line followed by CR → drains only 0x0D,0x0A.
- DEPTH=4: write "abcdef", CR → `o_ovf`=1 after the "e" write; drains "abcd",0x0D,0x0A; `o_ovf`=0 after the LF read.
- During `DRAIN`, pulse `i_wr` with "z" → ignored; `o_bsy`=1; "z" is absent from both this line and the next.
- Hold `i_rd` low for 5 cycles mid-drain → `o_data` and `o_rdy` stay stable; the line resumes intact.
- Assert `i_rst_n`=0 mid-drain → outputs go to reset values immediately; after release, a new "q", CR line drains "q",0x0D,0x0A.
